// File: rtl/obi_dram_arb_pkg.sv
// rtl/obi_dram_arb_pkg.sv - width helpers and ID FIFO entry type for the DRAM arbiter
package obi_dram_arb_pkg;

    localparam int ID_MAX_W = 8;

    // One FIFO entry records which master issued a granted transaction.
    typedef logic [ID_MAX_W-1:0] arb_id_t;

    function automatic int mst_idx_w(input int num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - OBI request/response bus types shared by masters and the DRAM slave
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/obi_dram_arb_id_fifo.sv
// rtl/obi_dram_arb_id_fifo.sv - in-order FIFO of issuing-master IDs for outstanding transactions
module obi_dram_arb_id_fifo
    import obi_dram_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = fifo_cnt_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  arb_id_t          data_i,
    input  logic             pop_i,
    output arb_id_t          data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    arb_id_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign data_o  = mem[rd_ptr];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/obi_dram_arbiter.sv
// rtl/obi_dram_arbiter.sv - round-robin OBI arbiter sharing one DRAM slave port among masters
module obi_dram_arbiter
    import obi_pkg::*;
    import obi_dram_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_OUTSTANDING = 4,
    localparam int IDX_W = mst_idx_w(NUM_MASTERS),
    localparam int CNT_W = fifo_cnt_w(MAX_OUTSTANDING)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  obi_req_t  [NUM_MASTERS-1:0]  mst_req_i,
    output obi_resp_t [NUM_MASTERS-1:0]  mst_resp_o,
    output obi_req_t                     dram_req_o,
    input  obi_resp_t                    dram_resp_i,
    output logic [CNT_W-1:0]             outstanding_o,
    output logic                         err_o
);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] lock_idx;
    logic             lock_valid;
    logic [IDX_W-1:0] winner;
    logic             issue_en;
    logic             hs;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    arb_id_t          fifo_head;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_MASTERS - 1)) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        logic [IDX_W-1:0] cand;
        logic             found;
        winner = rr_ptr;
        cand   = rr_ptr;
        found  = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && mst_req_i[cand].req) begin
                winner = cand;
                found  = 1'b1;
            end
            cand = next_idx(cand);
        end
        // A pending ungranted request keeps the bus until the slave accepts it.
        if (lock_valid) begin
            winner = lock_idx;
        end
    end

    // Full check uses the registered count, so a same-cycle pop does not reopen issue.
    assign issue_en   = mst_req_i[winner].req & ~fifo_full;
    assign dram_req_o = issue_en ? mst_req_i[winner] : '0;
    assign hs         = issue_en & dram_resp_i.gnt;
    assign pop        = dram_resp_i.rvalid & ~fifo_empty;

    always_comb begin
        mst_resp_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (IDX_W'(i) == winner) begin
                mst_resp_o[i].gnt = dram_resp_i.gnt & issue_en;
            end
            if (pop && (arb_id_t'(i) == fifo_head)) begin
                mst_resp_o[i].rvalid = 1'b1;
                mst_resp_o[i].rdata  = dram_resp_i.rdata;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_idx   <= '0;
            err_o      <= 1'b0;
        end else begin
            if (hs) begin
                rr_ptr     <= next_idx(winner);
                lock_valid <= 1'b0;
            end else if (dram_req_o.req) begin
                lock_valid <= 1'b1;
                lock_idx   <= winner;
            end else begin
                lock_valid <= 1'b0;
            end
            if (dram_resp_i.rvalid && fifo_empty) begin
                err_o <= 1'b1;
            end
        end
    end

    obi_dram_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .data_i  (arb_id_t'(winner)),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

endmodule

// File: tb/tb_obi_dram_arbiter.sv
// tb/tb_obi_dram_arbiter.sv - directed self-checking bench for obi_dram_arbiter
module tb_obi_dram_arbiter;
    import obi_pkg::*;

    logic            clk_i;
    logic            rst_ni;
    obi_req_t  [1:0] mst_req;
    obi_resp_t [1:0] mst_resp;
    obi_req_t        dram_req;
    obi_resp_t       dram_resp;
    logic [2:0]      outstanding;
    logic            err;

    int errors = 0;
    int checks = 0;

    obi_dram_arbiter #(
        .NUM_MASTERS     (2),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .mst_req_i     (mst_req),
        .mst_resp_o    (mst_resp),
        .dram_req_o    (dram_req),
        .dram_resp_i   (dram_resp),
        .outstanding_o (outstanding),
        .err_o         (err)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic set_req(input int m, input logic r, input logic [31:0] addr, input logic [31:0] wdata);
        mst_req[m].req   = r;
        mst_req[m].we    = 1'b1;
        mst_req[m].be    = 4'hF;
        mst_req[m].addr  = addr;
        mst_req[m].wdata = wdata;
    endtask

    task automatic set_slave(input logic gnt, input logic rvalid, input logic [31:0] rdata);
        dram_resp.gnt    = gnt;
        dram_resp.rvalid = rvalid;
        dram_resp.rdata  = rdata;
    endtask

    initial begin
        int exp_w;
        int prev;
        int rsp_cnt [2];
        rsp_cnt[0] = 0;
        rsp_cnt[1] = 0;
        mst_req   = '0;
        dram_resp = '0;
        rst_ni    = 1'b0;

        // Reset state
        tick; tick; settle;
        check_eq("rst_outstanding", 32'(outstanding), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_dram_req", 32'(dram_req.req), 0);
        check_eq("rst_m0_gnt", 32'(mst_resp[0].gnt), 0);
        check_eq("rst_m0_rvalid", 32'(mst_resp[0].rvalid), 0);
        tick; rst_ni = 1'b1;

        // Single master write, grant after 2 cycles, response next cycle
        tick; set_req(0, 1'b1, 32'h1000, 32'hDEADBEEF); set_slave(1'b0, 1'b0, 0); settle;
        check_eq("single_req", 32'(dram_req.req), 1);
        check_eq("single_addr", dram_req.addr, 32'h1000);
        check_eq("single_wdata", dram_req.wdata, 32'hDEADBEEF);
        check_eq("single_be", 32'(dram_req.be), 32'hF);
        check_eq("single_gnt_wait0", 32'(mst_resp[0].gnt), 0);
        tick; settle;
        check_eq("single_gnt_wait1", 32'(mst_resp[0].gnt), 0);
        tick; set_slave(1'b1, 1'b0, 0); settle;
        check_eq("single_gnt_m0", 32'(mst_resp[0].gnt), 1);
        check_eq("single_gnt_m1", 32'(mst_resp[1].gnt), 0);
        check_eq("single_out0", 32'(outstanding), 0);
        tick; mst_req[0].req = 1'b0; set_slave(1'b0, 1'b0, 0); settle;
        check_eq("single_out1", 32'(outstanding), 1);
        check_eq("single_idle_req", 32'(dram_req.req), 0);
        check_eq("single_no_regnt", 32'(mst_resp[0].gnt), 0);
        tick; set_slave(1'b0, 1'b1, 32'hCAFE0001); settle;
        check_eq("single_rvalid_m0", 32'(mst_resp[0].rvalid), 1);
        check_eq("single_rdata_m0", mst_resp[0].rdata, 32'hCAFE0001);
        check_eq("single_rvalid_m1", 32'(mst_resp[1].rvalid), 0);
        check_eq("single_rdata_m1", mst_resp[1].rdata, 0);
        tick; set_slave(1'b0, 1'b0, 0); settle;
        check_eq("single_out_back0", 32'(outstanding), 0);
        check_eq("single_rvalid_once", 32'(mst_resp[0].rvalid), 0);

        // Contention: 100 back-to-back transfers; rr_ptr is 1 after the M0 transfer
        exp_w = 1;
        prev  = -1;
        for (int n = 0; n < 100; n++) begin
            tick;
            set_req(0, 1'b1, 32'h1000, 32'h0);
            set_req(1, 1'b1, 32'h2000, 32'h1);
            set_slave(1'b1, prev >= 0, 32'h100 + 32'(n));
            settle;
            check_eq("rr_gnt_winner", 32'(mst_resp[exp_w].gnt), 1);
            check_eq("rr_gnt_other", 32'(mst_resp[1-exp_w].gnt), 0);
            check_eq("rr_addr", dram_req.addr, (exp_w == 0) ? 32'h1000 : 32'h2000);
            if (prev >= 0) begin
                check_eq("rr_rvalid", 32'(mst_resp[prev].rvalid), 1);
                check_eq("rr_rdata", mst_resp[prev].rdata, 32'h100 + 32'(n));
                check_eq("rr_rvalid_other", 32'(mst_resp[1-prev].rvalid), 0);
                check_eq("rr_outstanding", 32'(outstanding), 1);
            end
            for (int m = 0; m < 2; m++) if (mst_resp[m].rvalid) rsp_cnt[m]++;
            prev  = exp_w;
            exp_w = 1 - exp_w;
        end
        tick; mst_req = '0; set_slave(1'b0, 1'b1, 32'h100 + 32'd100); settle;
        check_eq("rr_last_rvalid", 32'(mst_resp[prev].rvalid), 1);
        for (int m = 0; m < 2; m++) if (mst_resp[m].rvalid) rsp_cnt[m]++;
        tick; set_slave(1'b0, 1'b0, 0); settle;
        check_eq("rr_drained", 32'(outstanding), 0);
        check_eq("rr_count_m0", 32'(rsp_cnt[0]), 50);
        check_eq("rr_count_m1", 32'(rsp_cnt[1]), 50);

        // Lock: prime rr_ptr to 0 with an M1 transfer, then M1 holds the bus through 5 ungranted cycles
        tick; set_req(1, 1'b1, 32'h2000, 32'h5); set_slave(1'b1, 1'b0, 0); settle;
        check_eq("lock_prime_gnt", 32'(mst_resp[1].gnt), 1);
        tick; set_req(1, 1'b1, 32'h2004, 32'h6); set_slave(1'b0, 1'b0, 0); settle;
        check_eq("lock_c1_addr", dram_req.addr, 32'h2004);
        for (int c = 2; c <= 5; c++) begin
            tick; set_req(0, 1'b1, 32'h1000, 32'h7); settle;
            check_eq("lock_hold_addr", dram_req.addr, 32'h2004);
            check_eq("lock_hold_m0_gnt", 32'(mst_resp[0].gnt), 0);
            check_eq("lock_hold_m1_gnt", 32'(mst_resp[1].gnt), 0);
        end
        tick; set_slave(1'b1, 1'b0, 0); settle;
        check_eq("lock_gnt_m1", 32'(mst_resp[1].gnt), 1);
        check_eq("lock_gnt_addr", dram_req.addr, 32'h2004);
        check_eq("lock_gnt_m0", 32'(mst_resp[0].gnt), 0);
        tick; mst_req[1].req = 1'b0; settle;
        check_eq("lock_next_m0_gnt", 32'(mst_resp[0].gnt), 1);
        check_eq("lock_next_addr", dram_req.addr, 32'h1000);
        tick; mst_req = '0; set_slave(1'b0, 1'b1, 32'hA1); settle;
        check_eq("lock_out3", 32'(outstanding), 3);
        check_eq("lock_rsp1_m1", 32'(mst_resp[1].rvalid), 1);
        check_eq("lock_rsp1_data", mst_resp[1].rdata, 32'hA1);
        tick; set_slave(1'b0, 1'b1, 32'hA2); settle;
        check_eq("lock_rsp2_m1", 32'(mst_resp[1].rvalid), 1);
        tick; set_slave(1'b0, 1'b1, 32'hA3); settle;
        check_eq("lock_rsp3_m0", 32'(mst_resp[0].rvalid), 1);
        check_eq("lock_rsp3_data", mst_resp[0].rdata, 32'hA3);
        tick; set_slave(1'b0, 1'b0, 0); settle;
        check_eq("lock_drained", 32'(outstanding), 0);

        // Backpressure: grants M1,M0,M1,M0 fill the FIFO; rr_ptr is 1 after the lock phase
        for (int n = 0; n < 4; n++) begin
            tick;
            set_req(0, 1'b1, 32'h1000, 32'h0);
            set_req(1, 1'b1, 32'h2000, 32'h1);
            set_slave(1'b1, 1'b0, 0);
            settle;
            check_eq("bp_gnt", 32'(mst_resp[(n % 2 == 0) ? 1 : 0].gnt), 1);
        end
        tick; settle;
        check_eq("bp_full_out", 32'(outstanding), 4);
        check_eq("bp_full_req", 32'(dram_req.req), 0);
        check_eq("bp_full_gnt0", 32'(mst_resp[0].gnt), 0);
        check_eq("bp_full_gnt1", 32'(mst_resp[1].gnt), 0);
        tick; set_slave(1'b1, 1'b1, 32'h11); settle;
        check_eq("bp_rsp11_m1", 32'(mst_resp[1].rvalid), 1);
        check_eq("bp_rsp11_data", mst_resp[1].rdata, 32'h11);
        check_eq("bp_pop_still_blocked", 32'(dram_req.req), 0);
        tick; set_slave(1'b1, 1'b1, 32'h22); settle;
        check_eq("bp_reopen_req", 32'(dram_req.req), 1);
        check_eq("bp_reopen_out", 32'(outstanding), 3);
        check_eq("bp_reopen_gnt_m1", 32'(mst_resp[1].gnt), 1);
        check_eq("bp_rsp22_m0", 32'(mst_resp[0].rvalid), 1);
        check_eq("bp_rsp22_data", mst_resp[0].rdata, 32'h22);
        tick; mst_req = '0; set_slave(1'b0, 1'b1, 32'h33); settle;
        check_eq("bp_out_pushpop", 32'(outstanding), 3);
        check_eq("bp_rsp33_m1", mst_resp[1].rdata, 32'h33);
        tick; set_slave(1'b0, 1'b1, 32'h44); settle;
        check_eq("bp_rsp44_m0", mst_resp[0].rdata, 32'h44);
        check_eq("bp_rsp44_m1_quiet", 32'(mst_resp[1].rvalid), 0);
        tick; set_slave(1'b0, 1'b1, 32'h55); settle;
        check_eq("bp_rsp55_m1", mst_resp[1].rdata, 32'h55);
        tick; set_slave(1'b0, 1'b0, 0); settle;
        check_eq("bp_drained", 32'(outstanding), 0);
        check_eq("bp_no_err", 32'(err), 0);

        // Spurious rvalid with nothing outstanding
        tick; set_slave(1'b0, 1'b1, 32'h77); settle;
        check_eq("err_drop_m0", 32'(mst_resp[0].rvalid), 0);
        check_eq("err_drop_m1", 32'(mst_resp[1].rvalid), 0);
        check_eq("err_not_yet", 32'(err), 0);
        tick; set_slave(1'b0, 1'b0, 0); settle;
        check_eq("err_set", 32'(err), 1);
        check_eq("err_out", 32'(outstanding), 0);

        // Reset with 2 outstanding and rr_ptr=1
        tick; set_req(1, 1'b1, 32'h2000, 32'h0); set_slave(1'b1, 1'b0, 0); settle;
        check_eq("rstm_gnt_m1", 32'(mst_resp[1].gnt), 1);
        tick; mst_req[1].req = 1'b0; set_req(0, 1'b1, 32'h1000, 32'h0); settle;
        check_eq("rstm_gnt_m0", 32'(mst_resp[0].gnt), 1);
        tick; mst_req = '0; set_slave(1'b0, 1'b0, 0); settle;
        check_eq("rstm_out2", 32'(outstanding), 2);
        rst_ni = 1'b0; settle;
        check_eq("rstm_out_cleared", 32'(outstanding), 0);
        check_eq("rstm_err_cleared", 32'(err), 0);
        tick; rst_ni = 1'b1;
        tick;
        set_req(0, 1'b1, 32'h1000, 32'h0);
        set_req(1, 1'b1, 32'h2000, 32'h0);
        settle;
        check_eq("rstm_rr_ptr0", dram_req.addr, 32'h1000);
        tick; mst_req = '0; set_slave(1'b0, 1'b1, 32'h99); settle;
        check_eq("rstm_stale_m0", 32'(mst_resp[0].rvalid), 0);
        check_eq("rstm_stale_m1", 32'(mst_resp[1].rvalid), 0);
        tick; set_slave(1'b0, 1'b0, 0); settle;
        check_eq("rstm_stale_err", 32'(err), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
